// File: rtl/mw_trig_rx_if.sv
// ---------------------------------------------------------------------------
// mw_trig_rx_if
//   System-bus register interface used by the microwave step-trigger
//   receiver. Groups the address/data/strobe signals of the standard
//   register bus so that the receiver and its bus master share one bundle.
//
//   Signals:
//     sys_addr  [31:0]  bus address (master -> slave)
//     sys_wdata [31:0]  write data (master -> slave)
//     sys_sel   [3:0]   byte select (master -> slave, ignored by the slave)
//     sys_wen           write enable (master -> slave)
//     sys_ren           read enable (master -> slave)
//     sys_rdata [31:0]  read data (slave -> master)
//     sys_ack           acknowledge (slave -> master)
//
//   Modports: master (bus driver), slave (register block).
// ---------------------------------------------------------------------------
interface mw_trig_rx_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        input  sys_rdata, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        output sys_rdata, sys_ack
    );
endinterface

// File: rtl/mw_trig_rx.sv
// ---------------------------------------------------------------------------
// mw_trig_rx
//   Receiver for the idle-high, low-going microwave step-trigger pulse.
//   The trigger line is synchronised into the ADC clock domain, each low
//   pulse is measured and checked against programmable minimum and maximum
//   widths, and every accepted pulse produces a one-cycle step strobe and
//   advances the step index. Configuration and event counters sit on the
//   system-bus register interface.
//
//   Parameters:
//     MAX_LEN_RST      reset value of the maximum pulse width register
//
//   Optional feature macro:
//     MW_TRIG_RX_PERIOD_EN  when defined, builds a period counter that
//                           reports the cycle distance between consecutive
//                           accepted pulses at offset 0x28; otherwise 0x28
//                           reads 0.
//
//   Ports:
//     adc_clk_i        ADC clock (only clock)
//     adc_rstn_i       asynchronous active-low reset
//     trig_i           external trigger, asynchronous, idle high
//     step_o           one-cycle strobe per accepted pulse
//     step_idx_o[31:0] accepted-step count
//     done_o           step limit reached
//     sys_bus          register bus (slave modport)
// ---------------------------------------------------------------------------
module mw_trig_rx #(
    parameter logic [31:0] MAX_LEN_RST = 32'd125000
) (
    input  logic        adc_clk_i,
    input  logic        adc_rstn_i,
    input  logic        trig_i,
    output logic        step_o,
    output logic [31:0] step_idx_o,
    output logic        done_o,
    mw_trig_rx_if.slave sys_bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_STUCK = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    logic        r_sync1;
    logic        r_sync2;
    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_low_cnt;

    logic        r_enable;
    logic [31:0] r_min_len;
    logic [31:0] r_max_len;
    logic [31:0] r_steps_max;

    logic [31:0] r_step_idx;
    logic [31:0] r_last_len;
    logic [31:0] r_glitch_cnt;
    logic [31:0] r_long_cnt;
    logic [31:0] r_ovr_cnt;
    logic        r_step;

    logic [31:0] r_rdata;
    logic        r_ack;

    logic [19:0] w_off;
    logic        w_clear;
    logic [31:0] w_min_eff;
    logic        w_done;
    logic        w_too_long;
    logic        w_start;
    logic        w_accept;
    logic        w_ovr;
    logic        w_glitch;
    logic        w_long;
    logic [31:0] w_last_period;
    logic [31:0] w_rdata;
    logic        w_unused_bus;

    assign w_off        = sys_bus.sys_addr[19:0];
    assign w_unused_bus = ^{sys_bus.sys_sel, sys_bus.sys_addr[31:20]};

    // Clear acts on the same edge that samples the write, so it needs no
    // storage and automatically reads back as 0.
    assign w_clear    = sys_bus.sys_wen && (w_off == 20'h00000) && sys_bus.sys_wdata[1];
    assign w_min_eff  = (r_min_len == 32'd0) ? 32'd1 : r_min_len;
    assign w_done     = (r_steps_max != 32'd0) && (r_step_idx == r_steps_max);
    assign w_too_long = (r_max_len != 32'd0) && (r_low_cnt >= r_max_len);

    // Two-flop synchroniser, idle-high so reset does not look like a pulse.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= trig_i;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Clear and a disabled receiver both force IDLE,
    // which discards any pulse in progress. The maximum-width check is
    // evaluated before the release, so a pulse reaching the limit is long
    // even if it ends in that very cycle.
    always_comb begin
        w_next_state = r_state;
        if (w_clear || !r_enable) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (!r_sync2) w_next_state = ST_LOW;
                ST_LOW: begin
                    if (w_too_long)   w_next_state = ST_STUCK;
                    else if (r_sync2) w_next_state = ST_IDLE;
                end
                ST_STUCK: if (r_sync2) w_next_state = ST_IDLE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // Event decode. Events are suppressed while disabled or clearing so
    // that clear always wins over an increment in the same cycle.
    always_comb begin
        w_start  = 1'b0;
        w_accept = 1'b0;
        w_ovr    = 1'b0;
        w_glitch = 1'b0;
        w_long   = 1'b0;
        if (r_enable && !w_clear) begin
            case (r_state)
                ST_IDLE: w_start = !r_sync2;
                ST_LOW: begin
                    if (w_too_long) begin
                        w_long = 1'b1;
                    end else if (r_sync2) begin
                        if (r_low_cnt >= w_min_eff) begin
                            w_ovr    = w_done;
                            w_accept = !w_done;
                        end else begin
                            w_glitch = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pulse width counter: 1 on the first low cycle, so the value at the
    // release equals the number of low cycles seen.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_low_cnt <= 32'd0;
        end else if (w_start) begin
            r_low_cnt <= 32'd1;
        end else if ((r_state == ST_LOW) && !r_sync2) begin
            r_low_cnt <= sat_inc(r_low_cnt);
        end
    end

    // Step outputs and event counters.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_step       <= 1'b0;
            r_step_idx   <= 32'd0;
            r_last_len   <= 32'd0;
            r_glitch_cnt <= 32'd0;
            r_long_cnt   <= 32'd0;
            r_ovr_cnt    <= 32'd0;
        end else if (w_clear) begin
            r_step       <= 1'b0;
            r_step_idx   <= 32'd0;
            r_last_len   <= 32'd0;
            r_glitch_cnt <= 32'd0;
            r_long_cnt   <= 32'd0;
            r_ovr_cnt    <= 32'd0;
        end else begin
            r_step <= w_accept;
            if (w_accept) begin
                r_step_idx <= sat_inc(r_step_idx);
                r_last_len <= r_low_cnt;
            end
            if (w_glitch) r_glitch_cnt <= sat_inc(r_glitch_cnt);
            if (w_long)   r_long_cnt   <= sat_inc(r_long_cnt);
            if (w_ovr)    r_ovr_cnt    <= sat_inc(r_ovr_cnt);
        end
    end

`ifdef MW_TRIG_RX_PERIOD_EN
    logic [31:0] r_period_cnt;
    logic [31:0] r_last_period;
    logic        r_period_armed;

    // The counter restarts at 1 on an acceptance so that on the next one it
    // holds exactly the edge-to-edge distance. Nothing is latched until a
    // first pulse has armed the measurement.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_period_cnt   <= 32'd0;
            r_last_period  <= 32'd0;
            r_period_armed <= 1'b0;
        end else if (w_clear) begin
            r_period_cnt   <= 32'd0;
            r_last_period  <= 32'd0;
            r_period_armed <= 1'b0;
        end else if (w_accept) begin
            r_period_cnt   <= 32'd1;
            r_period_armed <= 1'b1;
            if (r_period_armed) r_last_period <= r_period_cnt;
        end else begin
            r_period_cnt <= sat_inc(r_period_cnt);
        end
    end

    assign w_last_period = r_last_period;
`else
    assign w_last_period = 32'd0;
`endif

    // Configuration registers; a write is visible from the next cycle.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_enable    <= 1'b0;
            r_min_len   <= 32'd1250;
            r_max_len   <= MAX_LEN_RST;
            r_steps_max <= 32'd100;
        end else if (sys_bus.sys_wen) begin
            case (w_off)
                20'h00000: r_enable    <= sys_bus.sys_wdata[0];
                20'h00008: r_min_len   <= sys_bus.sys_wdata;
                20'h0000C: r_max_len   <= sys_bus.sys_wdata;
                20'h00010: r_steps_max <= sys_bus.sys_wdata;
                default: ;
            endcase
        end
    end

    // Read mux.
    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            20'h00000: w_rdata = {31'd0, r_enable};
            20'h00004: w_rdata = {28'd0, w_done, (r_state == ST_STUCK),
                                  (r_state == ST_LOW), r_sync2};
            20'h00008: w_rdata = r_min_len;
            20'h0000C: w_rdata = r_max_len;
            20'h00010: w_rdata = r_steps_max;
            20'h00014: w_rdata = r_step_idx;
            20'h00018: w_rdata = r_last_len;
            20'h0001C: w_rdata = r_glitch_cnt;
            20'h00020: w_rdata = r_long_cnt;
            20'h00024: w_rdata = r_ovr_cnt;
            20'h00028: w_rdata = w_last_period;
            default:   w_rdata = 32'd0;
        endcase
    end

    // Bus response, one cycle after the request.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack   <= sys_bus.sys_wen | sys_bus.sys_ren;
            r_rdata <= sys_bus.sys_ren ? w_rdata : 32'd0;
        end
    end

    assign step_o            = r_step;
    assign step_idx_o        = r_step_idx;
    assign done_o            = w_done;
    assign sys_bus.sys_rdata = r_rdata;
    assign sys_bus.sys_ack   = r_ack;

endmodule

// File: tb/tb_mw_trig_rx.sv
// ---------------------------------------------------------------------------
// tb_mw_trig_rx
//   Directed testbench for mw_trig_rx: normal, glitch, width boundaries,
//   stuck-low, step limit, back-to-back pulses, disable and clear during a
//   pulse, period measurement and reset during a pulse.
// ---------------------------------------------------------------------------
module tb_mw_trig_rx;

    logic        clk;
    logic        rstN;
    logic        trig;
    logic        stepO;
    logic [31:0] stepIdx;
    logic        doneO;

    int vecCount    = 0;
    int errCount    = 0;
    int strobeCount = 0;
    int strobeBase;
    logic [31:0] rd;

    mw_trig_rx_if sysBus();

    mw_trig_rx dut (
        .adc_clk_i  (clk),
        .adc_rstn_i (rstN),
        .trig_i     (trig),
        .step_o     (stepO),
        .step_idx_o (stepIdx),
        .done_o     (doneO),
        .sys_bus    (sysBus)
    );

    // 125 MHz ADC clock.
    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Count strobes once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (stepO === 1'b1) strobeCount <= strobeCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            errCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Hold trig low for lowCycles sampled cycles, then release. Starts and
    // ends on a falling clock edge.
    task automatic applyStimulus(input int lowCycles);
        trig = 1'b0;
        repeat (lowCycles) @(negedge clk);
        trig = 1'b1;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        sysBus.sys_addr  = addr;
        sysBus.sys_wdata = data;
        sysBus.sys_wen   = 1'b1;
        @(negedge clk);
        sysBus.sys_wen   = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
        sysBus.sys_addr = addr;
        sysBus.sys_ren  = 1'b1;
        @(negedge clk);
        sysBus.sys_ren  = 1'b0;
        checkOutput("ack", 32'(sysBus.sys_ack), 32'd1);
        data = sysBus.sys_rdata;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rstN             = 1'b0;
        trig             = 1'b1;
        sysBus.sys_addr  = 32'd0;
        sysBus.sys_wdata = 32'd0;
        sysBus.sys_sel   = 4'hF;
        sysBus.sys_wen   = 1'b0;
        sysBus.sys_ren   = 1'b0;
        idle(3);

        $display("[TB] reset state");
        checkOutput("rst_step", 32'(stepO), 32'd0);
        checkOutput("rst_idx", stepIdx, 32'd0);
        checkOutput("rst_done", 32'(doneO), 32'd0);
        checkOutput("rst_ack", 32'(sysBus.sys_ack), 32'd0);
        checkOutput("rst_rdata", sysBus.sys_rdata, 32'd0);
        rstN = 1'b1;
        idle(2);
        busRead(32'h08, rd); checkOutput("min_rst", rd, 32'd1250);
        busRead(32'h0C, rd); checkOutput("max_rst", rd, 32'd125000);
        busRead(32'h10, rd); checkOutput("steps_rst", rd, 32'd100);
        busRead(32'h00, rd); checkOutput("en_rst", rd, 32'd0);

        $display("[TB] normal pulse");
        busWrite(32'h00, 32'd1);
        busRead(32'h00, rd); checkOutput("en_set", rd, 32'd1);
        strobeBase = strobeCount;
        applyStimulus(3750);
        @(negedge clk); checkOutput("strobe_c1", 32'(stepO), 32'd0);
        @(negedge clk); checkOutput("strobe_c2", 32'(stepO), 32'd0);
        @(negedge clk); checkOutput("strobe_c3", 32'(stepO), 32'd1);
        checkOutput("idx_with_strobe", stepIdx, 32'd1);
        @(negedge clk); checkOutput("strobe_c4", 32'(stepO), 32'd0);
        busRead(32'h18, rd); checkOutput("last_len_3750", rd, 32'd3750);
        busRead(32'h1C, rd); checkOutput("glitch_0", rd, 32'd0);
        checkOutput("strobes_normal", 32'(strobeCount - strobeBase), 32'd1);

        $display("[TB] glitch and minimum-width boundary");
        applyStimulus(100); idle(5);
        busRead(32'h1C, rd); checkOutput("glitch_1", rd, 32'd1);
        checkOutput("idx_after_glitch", stepIdx, 32'd1);
        applyStimulus(1249); idle(5);
        busRead(32'h1C, rd); checkOutput("glitch_1249", rd, 32'd2);
        applyStimulus(1250); idle(5);
        checkOutput("idx_1250", stepIdx, 32'd2);
        busRead(32'h18, rd); checkOutput("last_len_1250", rd, 32'd1250);

        $display("[TB] maximum-width boundary and stuck low");
        busWrite(32'h0C, 32'd5000);
        applyStimulus(4999); idle(5);
        checkOutput("idx_4999", stepIdx, 32'd3);
        strobeBase = strobeCount;
        trig = 1'b0;
        idle(3000);
        busRead(32'h04, rd); checkOutput("status_low", rd, 32'h2);
        idle(5000);
        busRead(32'h04, rd); checkOutput("status_stuck", rd, 32'h4);
        idle(1998);
        trig = 1'b1;
        idle(5);
        busRead(32'h04, rd); checkOutput("status_released", rd, 32'h1);
        busRead(32'h20, rd); checkOutput("long_1", rd, 32'd1);
        checkOutput("idx_after_stuck", stepIdx, 32'd3);
        checkOutput("strobes_stuck", 32'(strobeCount - strobeBase), 32'd0);

        $display("[TB] read-only and unmapped offsets");
        busWrite(32'h14, 32'hFF);
        busRead(32'h14, rd); checkOutput("idx_ro", rd, 32'd3);
        busRead(32'h2C, rd); checkOutput("unmapped", rd, 32'd0);

        $display("[TB] clear");
        busWrite(32'h00, 32'd3);
        busRead(32'h00, rd); checkOutput("clear_reads0", rd, 32'd1);
        checkOutput("idx_cleared", stepIdx, 32'd0);
        busRead(32'h1C, rd); checkOutput("glitch_cleared", rd, 32'd0);
        busRead(32'h20, rd); checkOutput("long_cleared", rd, 32'd0);
        busRead(32'h18, rd); checkOutput("last_len_cleared", rd, 32'd0);

        $display("[TB] step limit");
        busWrite(32'h10, 32'd3);
        strobeBase = strobeCount;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1300);
            idle(10);
        end
        checkOutput("idx_limit", stepIdx, 32'd3);
        checkOutput("done_limit", 32'(doneO), 32'd1);
        busRead(32'h24, rd); checkOutput("ovr_2", rd, 32'd2);
        busRead(32'h04, rd); checkOutput("status_done", rd, 32'h9);
        checkOutput("strobes_limit", 32'(strobeCount - strobeBase), 32'd3);

        $display("[TB] back-to-back pulses");
        busWrite(32'h00, 32'd3);
        busWrite(32'h10, 32'd0);
        busWrite(32'h08, 32'd2);
        strobeBase = strobeCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3);
            @(negedge clk);
        end
        idle(5);
        checkOutput("idx_b2b", stepIdx, 32'd4);
        busRead(32'h18, rd); checkOutput("last_len_b2b", rd, 32'd3);
        checkOutput("strobes_b2b", 32'(strobeCount - strobeBase), 32'd4);

        $display("[TB] disable during pulse");
        busWrite(32'h08, 32'd1250);
        trig = 1'b0;
        idle(1500);
        busWrite(32'h00, 32'd0);
        idle(500);
        trig = 1'b1;
        idle(5);
        busRead(32'h1C, rd); checkOutput("glitch_disable", rd, 32'd0);
        busRead(32'h20, rd); checkOutput("long_disable", rd, 32'd0);
        checkOutput("idx_disable", stepIdx, 32'd4);
        busWrite(32'h00, 32'd1);

        $display("[TB] clear on acceptance cycle");
        strobeBase = strobeCount;
        applyStimulus(1300);
        @(negedge clk);
        @(negedge clk);
        busWrite(32'h00, 32'd3);
        idle(3);
        checkOutput("idx_clear_accept", stepIdx, 32'd0);
        checkOutput("strobes_clear_accept", 32'(strobeCount - strobeBase), 32'd0);

        $display("[TB] period");
        busWrite(32'h00, 32'd3);
        applyStimulus(1300);
        idle(11200);
        applyStimulus(1300);
        idle(5);
        checkOutput("idx_period", stepIdx, 32'd2);
        busRead(32'h28, rd);
`ifdef MW_TRIG_RX_PERIOD_EN
        checkOutput("last_period", rd, 32'd12500);
`else
        checkOutput("last_period", rd, 32'd0);
`endif

        $display("[TB] reset during pulse");
        strobeBase = strobeCount;
        trig = 1'b0;
        idle(500);
        rstN = 1'b0;
        #1;
        checkOutput("rst_mid_step", 32'(stepO), 32'd0);
        checkOutput("rst_mid_idx", stepIdx, 32'd0);
        checkOutput("rst_mid_done", 32'(doneO), 32'd0);
        checkOutput("rst_mid_ack", 32'(sysBus.sys_ack), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        idle(100);
        trig = 1'b1;
        idle(10);
        checkOutput("rst_mid_strobes", 32'(strobeCount - strobeBase), 32'd0);
        checkOutput("rst_mid_idx_after", stepIdx, 32'd0);
        busRead(32'h00, rd); checkOutput("rst_mid_en", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
